// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared constants and helpers for the EDSAC-style mercury tank memory.
//   MT_WORDS        default number of short-word slots per tank
//   MT_DIGITS       default digit times per slot (17 data digits + gap)
//   EDSAC_DIGIT_HZ  digit strobe rate of the original machine
//   tank_src_e      source selected for the bit entering the tank
//   clog2()         width helper, never returns less than 1
// Optional build macro consumed by users of this package: MEMORY_TANK_LONG_EN
// -----------------------------------------------------------------------------
package memory_pkg;

   localparam int unsigned MT_WORDS       = 32;
   localparam int unsigned MT_DIGITS      = 18;
   localparam int unsigned EDSAC_DIGIT_HZ = 500_000;

   typedef enum logic [1:0] {
      SRC_RECIRC = 2'd0,
      SRC_MIB    = 2'd1,
      SRC_ZERO   = 2'd2
   } tank_src_e;

   // Minimum width 1 so a degenerate parameter never yields a zero-width vector.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) w = i + 1;
      end
      return w;
   endfunction

endpackage : memory_pkg

// File: rtl/memory_delay_line.sv
// -----------------------------------------------------------------------------
// memory_delay_line
// DEPTH-bit serial circulating store. Each enable shifts one bit in and
// presents the oldest bit on dout; a bit entered now reappears on dout after
// exactly DEPTH enables.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset, clears the whole line
//   en     in   shift enable (one digit time)
//   din    in   serial data in
//   dout   out  serial data out (tail of the line)
// -----------------------------------------------------------------------------
module memory_delay_line #(
   parameter int unsigned DEPTH = 576
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] line_q;
   logic [DEPTH-1:0] line_d;

   always_comb begin
      line_d = line_q;
      if (en) line_d = {line_q[DEPTH-2:0], din};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) line_q <= '0;
      else        line_q <= line_d;
   end

   assign dout = line_q[DEPTH-1];

endmodule : memory_delay_line

// File: rtl/memory_tank.sv
// -----------------------------------------------------------------------------
// memory_tank
// One mercury tank: a WORDS x DIGITS serial store with digit/slot counters,
// an addressed window and write/clear/read gating.
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   dig_en      in   digit strobe, advances the tank one digit
//   mib         in   memory input bus (serial)
//   wr_en       in   write gate
//   rd_en       in   read gate
//   clr         in   clear gate (wins over write)
//   slot_sel    in   selected slot; values >= WORDS never match
//   long_en     in   slot-pair access (only with MEMORY_TANK_LONG_EN)
//   mob         out  memory output bus, registered
//   monitor     out  bit currently leaving the tank
//   digit       out  current digit index
//   slot        out  current slot index
//   slot_start  out  high while digit == 0
// Build macro: MEMORY_TANK_LONG_EN enables even-aligned slot-pair windows.
// -----------------------------------------------------------------------------
module memory_tank
   import memory_pkg::*;
#(
   parameter  int unsigned WORDS  = MT_WORDS,
   parameter  int unsigned DIGITS = MT_DIGITS,
   localparam int unsigned DEPTH  = WORDS * DIGITS,
   localparam int unsigned SLOT_W = clog2(WORDS),
   localparam int unsigned DIG_W  = clog2(DIGITS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dig_en,
   input  logic              mib,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              clr,
   input  logic [SLOT_W-1:0] slot_sel,
   input  logic              long_en,
   output logic              mob,
   output logic              monitor,
   output logic [DIG_W-1:0]  digit,
   output logic [SLOT_W-1:0] slot,
   output logic              slot_start
);

   localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DIGITS - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(WORDS - 1);
   localparam logic [SLOT_W:0]   WORDS_EXT  = (SLOT_W + 1)'(WORDS);

   logic [DIG_W-1:0]  digit_q, digit_d;
   logic [SLOT_W-1:0] slot_q,  slot_d;
   logic              mob_q,   mob_d;

   logic              tail;
   logic              tank_in;
   logic              window;
   logic              sel_in_range;
   logic              pair_mode;
   tank_src_e         src;

`ifdef MEMORY_TANK_LONG_EN
   assign pair_mode = long_en;
`else
   logic unused_long_en;
   assign unused_long_en = long_en;
   assign pair_mode      = 1'b0;
`endif

   // Pair match compares everything but the LSB, giving even-aligned pairs.
   always_comb begin
      sel_in_range = ({1'b0, slot_sel} < WORDS_EXT);
      window       = 1'b0;
      if (sel_in_range) begin
         if (pair_mode) window = ((slot_q >> 1) == (slot_sel >> 1));
         else           window = (slot_q == slot_sel);
      end
   end

   always_comb begin
      digit_d = digit_q;
      slot_d  = slot_q;
      mob_d   = mob_q;
      src     = SRC_RECIRC;
      tank_in = tail;

      if (clr && window)        src = SRC_ZERO;
      else if (wr_en && window) src = SRC_MIB;

      case (src)
         SRC_ZERO: tank_in = 1'b0;
         SRC_MIB:  tank_in = mib;
         default:  tank_in = tail;
      endcase

      if (dig_en) begin
         // Read returns the tail before this digit's write takes effect.
         mob_d = tail & rd_en & window;
         if (digit_q == DIGIT_LAST) begin
            digit_d = '0;
            slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
         end else begin
            digit_d = digit_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit_q <= '0;
         slot_q  <= '0;
         mob_q   <= 1'b0;
      end else begin
         digit_q <= digit_d;
         slot_q  <= slot_d;
         mob_q   <= mob_d;
      end
   end

   memory_delay_line #(
      .DEPTH (DEPTH)
   ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dig_en),
      .din   (tank_in),
      .dout  (tail)
   );

   assign mob        = mob_q;
   assign monitor    = tail;
   assign digit      = digit_q;
   assign slot       = slot_q;
   assign slot_start = (digit_q == '0);

endmodule : memory_tank

// File: doc/memory_tank.md
MEMORY_TANK -- requirements
Module: memory_tank

Interface
REQ-001 The block SHALL expose parameter WORDS, default 32, number of short-word slots in the tank.
REQ-002 The block SHALL expose parameter DIGITS, default 18, digit times per slot (17 data digits plus gap).
REQ-003 Derived: DEPTH = WORDS*DIGITS (default 576, i.e. 1.152 ms at 500 kHz); SLOT_W = clog2(WORDS); DIG_W = clog2(DIGITS).
REQ-004 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  reset: synchronous, active-low.
- dig_en  in  1  digit strobe; advances the tank one digit.
- mib  in  1  memory input bus, serial.
- wr_en  in  1  write gate.
- rd_en  in  1  read gate.
- clr  in  1  clear gate.
- slot_sel  in  SLOT_W  selected slot address.
- long_en  in  1  long-word (slot-pair) access.
- mob  out  1  memory output bus, registered.
- monitor  out  1  bit leaving the tank (CRT monitor).
- digit  out  DIG_W  current digit index.
- slot  out  SLOT_W  current slot index.
- slot_start  out  1  high while digit==0.

Function
REQ-005 The tank SHALL be a circulating DEPTH-bit serial store; monitor SHALL equal the tail bit, i.e. the stored bit for (slot, digit).
REQ-006 With dig_en low, all state and outputs SHALL hold; all inputs SHALL be sampled only on clk edges with dig_en high.
REQ-007 On each dig_en, digit SHALL increment, wrapping DIGITS-1->0; on that wrap, slot SHALL increment, wrapping WORDS-1->0.
REQ-008 Window SHALL be active when slot==slot_sel; with long_en, it SHALL be active when slot[SLOT_W-1:1]==slot_sel[SLOT_W-1:1] (even-aligned pair, 2*DIGITS digits).
REQ-009 slot_sel>=WORDS SHALL never match.
REQ-010 The bit entering the tank on dig_en SHALL be, in priority order: 0 if clr and window; mib if wr_en and window; otherwise the tail bit (recirculation).
REQ-011 clr and wr_en together SHALL clear; rd_en SHALL never alter contents.
REQ-012 On dig_en, mob SHALL load tail & rd_en & window, and 0 otherwise; mob therefore lags monitor by one dig_en.
REQ-013 A bit written at a (slot, digit) SHALL reappear on monitor exactly DEPTH dig_en strobes later; read-during-write in the same window SHALL return the old contents.
REQ-014 Gates changing mid-window SHALL take effect per digit, with no slot-level latching.

Reset
REQ-015 On rst_n low at clk, regardless of dig_en: storage all 0; digit=0; slot=0; mob=0; monitor=0; slot_start=1.
REQ-016 Reset mid-write SHALL discard the partial word; first dig_en after release SHALL address (slot 0, digit 0).

Configuration
REQ-017 Macro MEMORY_TANK_LONG_EN defined: long_en SHALL behave per REQ-008.
REQ-018 Macro MEMORY_TANK_LONG_EN undefined: long_en SHALL be ignored and the window SHALL be single-slot only.

Structure
REQ-019 Package memory_pkg SHALL hold default WORDS/DIGITS constants, the EDSAC digit-rate constant, and the clog2 width helper.
REQ-020 Storage SHALL be sub-module memory_delay_line (parameter DEPTH, enable, serial in/out), so that later tanks reuse it.
REQ-021 Counters, window decode and gating SHALL reside in memory_tank.

Verification
REQ-022 Reset, then 576 dig_en with all gates low -> monitor and mob stay 0; slot wraps 31->0 once; slot_start pulses 32 times.
REQ-023 slot_sel=5, wr_en=1, mib pattern 18'h2A5C5 over slot 5 -> the same pattern appears on monitor in slot 5 of the next revolution, and on mob when rd_en=1 with mob one digit later.
REQ-024 Write slot 7 all ones, then clr=1 with wr_en=1, mib=1 on slot 7 -> slot 7 reads all 0; slots 6 and 8 are unchanged.
REQ-025 With MEMORY_TANK_LONG_EN: long_en=1, slot_sel=9, write 36 ones -> slots 8 and 9 read all 1, slot 10 reads 0. Without the macro -> only slot 9 is written.
REQ-026 Assert rst_n low at digit 10 of slot 3 while writing -> all outputs are reset next clk; contents are 0 on the next revolution.
REQ-027 Drive dig_en at 1-in-4 clk with slot_sel=31 (WORDS=32) and slot_sel=40 on a WORDS=40, slot_sel=40 build -> slot 31 is written; the out-of-range select never writes.
